// File: rtl/clut_fader.sv
// Palette fade engine: streams a source palette out of BRAM, scales each colour
// channel by a latched fade level and writes one CLUT entry per clock.
module clut_fader #(
    parameter int COLRW = 12,
    parameter int CIDXW = 4,
    parameter int FRACW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [FRACW:0]   level,
    output logic             busy,
    output logic             done,
    output logic [CIDXW-1:0] src_addr,
    input  logic [COLRW-1:0] src_data,
    output logic             clut_we,
    output logic [CIDXW-1:0] clut_cidx,
    output logic [COLRW-1:0] clut_colr
);

    localparam int CHANW = COLRW / 3;
    localparam int PRODW = CHANW + FRACW + 1;
    localparam logic [FRACW:0]   FULL_LVL = {1'b1, {FRACW{1'b0}}};
    localparam logic [CIDXW-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t             state_q, state_d;
    logic [FRACW:0]     lvl_q;
    logic [FRACW:0]     lvl_clamped;
    logic               d_valid;
    logic [CIDXW-1:0]   d_idx;
    logic [COLRW-1:0]   scaled;

    assign lvl_clamped = (level > FULL_LVL) ? FULL_LVL : level;
    assign busy        = (state_q == RUN) || (state_q == FLUSH);
    assign done        = (state_q == DONE);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (src_addr == LAST_IDX) state_d = FLUSH;
            FLUSH:   if (clut_we && (clut_cidx == LAST_IDX)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-channel scale; the product width keeps lvl_q == 2^FRACW lossless.
    always_comb begin
        logic [PRODW-1:0] prod;
        scaled = '0;
        prod   = '0;
        for (int c = 0; c < 3; c++) begin
            prod = PRODW'(src_data[c*CHANW +: CHANW]) * PRODW'(lvl_q);
            scaled[c*CHANW +: CHANW] = CHANW'(prod >> FRACW);
        end
    end

    // NOTE: state registers use non-blocking assignments so every stage sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lvl_q     <= '0;
            src_addr  <= '0;
            d_valid   <= 1'b0;
            d_idx     <= '0;
            clut_we   <= 1'b0;
            clut_cidx <= '0;
            clut_colr <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (start) begin
                    lvl_q    <= lvl_clamped;
                    src_addr <= '0;
                end
                RUN:     src_addr <= src_addr + 1'b1;
                default: ;
            endcase
            // BRAM data lands one cycle after its address; index and valid follow it.
            d_valid <= (state_q == RUN);
            d_idx   <= src_addr;
            clut_we <= d_valid;
            if (d_valid) begin
                clut_cidx <= d_idx;
                clut_colr <= scaled;
            end
        end
    end

endmodule

// File: tb/tb_clut_fader.sv
// Randomized bench for clut_fader: BRAM model plus an arithmetic reference for
// per-cycle timing, write contents, ignore rules and mid-pass reset.
module tb_clut_fader;

    localparam int COLRW = 12;
    localparam int CIDXW = 4;
    localparam int FRACW = 4;
    localparam int N     = 1 << CIDXW;
    localparam int CHANW = COLRW / 3;
    localparam int FULL  = 1 << FRACW;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [FRACW:0]   level;
    logic             busy;
    logic             done;
    logic [CIDXW-1:0] src_addr;
    logic [COLRW-1:0] src_data;
    logic             clut_we;
    logic [CIDXW-1:0] clut_cidx;
    logic [COLRW-1:0] clut_colr;

    logic [COLRW-1:0] mem [N];
    int cmp_count = 0;
    int err_count = 0;

    always #5 clk = ~clk;

    always @(posedge clk) src_data <= mem[src_addr];

    clut_fader #(.COLRW(COLRW), .CIDXW(CIDXW), .FRACW(FRACW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .level(level),
        .busy(busy), .done(done), .src_addr(src_addr), .src_data(src_data),
        .clut_we(clut_we), .clut_cidx(clut_cidx), .clut_colr(clut_colr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_colour(input int colour, input int lvl);
        int eff, res, chan;
        eff = (lvl > FULL) ? FULL : lvl;
        res = 0;
        for (int ch = 0; ch < 3; ch++) begin
            chan = (colour / (1 << (ch*CHANW))) % (1 << CHANW);
            res += ((chan * eff) / FULL) * (1 << (ch*CHANW));
        end
        return res;
    endfunction

    // mode 0: plain pass; 1: start pulse and level=0 at T+5; 2: reset at T+8.
    // Entered and left at a negedge in an IDLE cycle, so passes may run back-to-back.
    task automatic run_pass(input int lvl, input int mode);
        int writes = 0;
        int dones  = 0;
        level = FRACW'(0) | lvl[FRACW:0];
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= N + 4; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 2) level = FRACW'(0) | ($urandom % (2*FULL));
            if (mode == 2 && k >= 9) begin
                check("rst_we", clut_we, 1'b0);
                check("rst_busy", busy, 1'b0);
                check("rst_done", done, 1'b0);
                check("rst_addr", src_addr, 0);
                if (k == 11) rst_n = 1'b1;
                if (k == 12) return;
                continue;
            end
            check("busy", busy, (k <= N + 2));
            check("done", done, (k == N + 3));
            check("we", clut_we, (k >= 3 && k <= N + 2));
            if (k <= N) check("src_addr", src_addr, k - 1);
            if (clut_we) begin
                writes++;
                check("cidx", clut_cidx, k - 3);
                if (k >= 3 && k <= N + 2)
                    check("colr", clut_colr, ref_colour(mem[k-3], lvl));
            end
            if (done) dones++;
            if (mode == 1 && k == 5) begin
                start = 1'b1;
                level = '0;
            end
            if (mode == 1 && k == 6) start = 1'b0;
            if (mode == 2 && k == 8) rst_n = 1'b0;
        end
        check("write_count", writes, N);
        check("done_count", dones, 1);
    endtask

    task automatic random_palette();
        for (int i = 0; i < N; i++) mem[i] = COLRW'($urandom_range(0, (1 << COLRW) - 1));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        level = '0;
        for (int i = 0; i < N; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_we", clut_we, 1'b0);
        check("reset_cidx", clut_cidx, 0);
        check("reset_colr", clut_colr, 0);
        check("reset_addr", src_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < N; i++) mem[i] = COLRW'(i * 'h111);
        run_pass(FULL, 0);

        random_palette();
        run_pass(0, 0);

        random_palette();
        mem[0] = 12'hFFF;
        mem[1] = 12'hA53;
        run_pass(8, 0);
        check("fixed_8", ref_colour('hFFF, 8), 'h777);
        run_pass(5, 0);
        check("fixed_5", ref_colour('hA53, 5), 'h310);
        run_pass(31, 0);

        random_palette();
        run_pass(FULL, 1);

        random_palette();
        run_pass(9, 2);
        run_pass(12, 0);

        for (int p = 0; p < 6; p++) begin
            random_palette();
            run_pass($urandom % (2*FULL), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
